// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int parity_en);
    return (2 + data_w + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: bit_end pulses in the last cycle of every CLKS_PER_BIT
// period; restart realigns it so a fresh period begins on the next cycle.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap after the last cycle of a bit, or realign on restart
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/fifo_word_serializer.sv
// FIFO drain stage: pops one word per frame and shifts it onto tx as a
// UART-style frame (start, data LSB first, optional parity, stop).
// Only ever pops, never pushes. Also keeps a sticky FIFO error flag.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_error,
  input  logic [DATA_W-1:0] fifo_dataout,
  input  logic              clear_err,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sticky
);

  localparam int            BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
  localparam logic          PAR_SENSE  = (PARITY_ODD != 0);
  localparam bit            HAS_PARITY = (PARITY_EN != 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              fifo_pop_q, fifo_pop_d;
  logic              err_q, err_d;
  logic              bit_end;
  logic              baud_restart;
  logic              can_start;

  assign can_start    = enable && !fifo_empty;
  // The bit timer is realigned in LOAD so START gets a full bit period.
  assign baud_restart = (state_q == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(baud_restart),
    .bit_end(bit_end)
  );

  // Next-state, next-tx and datapath updates; tx is computed one cycle
  // ahead so the serial line comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    fifo_pop_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          state_d    = POP;
          fifo_pop_d = 1'b1;
        end
      end
      POP: begin
        tx_d    = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid now, one cycle after the pop.
        shreg_d   = fifo_dataout;
        par_d     = (^fifo_dataout) ^ PAR_SENSE;
        bit_cnt_d = '0;
        tx_d      = 1'b0;
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (HAS_PARITY) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (can_start) begin
            state_d    = POP;
            fifo_pop_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Error latch: a new error beats a simultaneous clear.
    if (clear_err)  err_d = 1'b0;
    if (fifo_error) err_d = 1'b1;
  end

  // Control state: FSM, bit counter, registered outputs and error latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      fifo_pop_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      fifo_pop_q <= fifo_pop_d;
      err_q      <= err_d;
    end
  end

  // Data word and its parity; always reloaded in LOAD before use
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign fifo_pop   = fifo_pop_q;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_end;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: three instances (default even parity,
// odd parity, and no parity with 2 clocks per bit) fed by FIFO models.
module tb_fifo_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v, en, ferr, clr, fempty;
  logic [2:0]  pop, tx, busy, fd, errs;
  logic [15:0] dout [3];

  logic [15:0] fmem    [3][64];
  logic [15:0] exp_mem [3][64];
  logic        ep_mem  [3][64];
  int wp [3], rp [3], ewp [3], erp [3];
  int pops [3], frames [3], gap [3], last_gap [3];
  logic [2:0] underflow, fd_stray;

  int nvec = 0;
  int nfail = 0;

  fifo_word_serializer #(.DATA_W(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst_v[0]), .enable(en[0]), .fifo_empty(fempty[0]), .fifo_error(ferr[0]),
    .fifo_dataout(dout[0]), .clear_err(clr[0]), .fifo_pop(pop[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(fd[0]), .err_sticky(errs[0]));

  fifo_word_serializer #(.DATA_W(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst_v[1]), .enable(en[1]), .fifo_empty(fempty[1]), .fifo_error(ferr[1]),
    .fifo_dataout(dout[1]), .clear_err(clr[1]), .fifo_pop(pop[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(fd[1]), .err_sticky(errs[1]));

  fifo_word_serializer #(.DATA_W(16), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst(rst_v[2]), .enable(en[2]), .fifo_empty(fempty[2]), .fifo_error(ferr[2]),
    .fifo_dataout(dout[2]), .clear_err(clr[2]), .fifo_pop(pop[2]), .tx(tx[2]), .busy(busy[2]),
    .frame_done(fd[2]), .err_sticky(errs[2]));

  function automatic int cpb_of(input int c);
    return (c == 2) ? 2 : 4;
  endfunction

  function automatic int pen_of(input int c);
    return (c == 2) ? 0 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [15:0] w, input logic p);
    fmem[c][wp[c]]     = w;
    exp_mem[c][ewp[c]] = w;
    ep_mem[c][ewp[c]]  = p;
    wp[c]  = wp[c] + 1;
    ewp[c] = ewp[c] + 1;
  endtask

  task automatic wait_frames(input int c, input int n, input int budget);
    int k;
    k = 0;
    while (frames[c] < n && k < budget) begin
      tick(1);
      k++;
    end
    chk($sformatf("ch%0d_frames_done", c), frames[c], n);
  endtask

  always_comb begin
    for (int c = 0; c < 3; c++) fempty[c] = (rp[c] == wp[c]);
  end

  // FIFO models with one cycle of read latency
  initial begin : fifo_model
    underflow = '0;
    for (int c = 0; c < 3; c++) dout[c] = '0;
    forever begin
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
        if (pop[c] === 1'b1) begin
          pops[c]++;
          if (rp[c] != wp[c]) begin
            dout[c] <= fmem[c][rp[c]];
            rp[c]   <= rp[c] + 1;
          end else begin
            underflow[c] = 1'b1;
          end
        end
      end
    end
  end

  // Serial-line decoder and frame scoreboard
  initial begin : monitor
    logic [2:0]  mst, cur, stable, fdok, rxp, rxs, epv;
    logic [15:0] rxw [3];
    logic [15:0] ew  [3];
    int          cyc [3];
    int          nb, fl, bi, ps;
    mst      = '0;
    fd_stray = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (rst_v[c]) begin
          mst[c] = 1'b0;
          gap[c] = 0;
        end else begin
          if (!mst[c]) begin
            if (fd[c] !== 1'b0) fd_stray[c] = 1'b1;
            if (tx[c] !== 1'b0) begin
              gap[c]++;
            end else begin
              mst[c] = 1'b1; cyc[c] = 0; last_gap[c] = gap[c];
              stable[c] = 1'b1; fdok[c] = 1'b1;
              rxw[c] = '0; rxp[c] = 1'b0; rxs[c] = 1'b0;
              chk($sformatf("ch%0d_frame_expected", c), (ewp[c] > erp[c]), 1);
              if (ewp[c] > erp[c]) begin
                ew[c]  = exp_mem[c][erp[c]];
                epv[c] = ep_mem[c][erp[c]];
                erp[c] = erp[c] + 1;
              end else begin
                ew[c]  = '0;
                epv[c] = 1'b0;
              end
            end
          end
          if (mst[c]) begin
            nb = 2 + 16 + pen_of(c);
            fl = nb * cpb_of(c);
            bi = cyc[c] / cpb_of(c);
            ps = cyc[c] % cpb_of(c);
            if (ps == 0) begin
              cur[c] = tx[c];
              if (bi >= 1 && bi <= 16) rxw[c][4'(bi - 1)] = tx[c];
              else if (bi == 17 && pen_of(c) == 1) rxp[c] = tx[c];
              if (bi == nb - 1) rxs[c] = tx[c];
            end else if (tx[c] !== cur[c]) begin
              stable[c] = 1'b0;
            end
            if (fd[c] !== (cyc[c] == fl - 1)) fdok[c] = 1'b0;
            if (cyc[c] == fl - 1) begin
              chk($sformatf("ch%0d_frame%0d_data", c, frames[c]), rxw[c], ew[c]);
              if (pen_of(c) == 1)
                chk($sformatf("ch%0d_frame%0d_parity", c, frames[c]), rxp[c], epv[c]);
              chk($sformatf("ch%0d_frame%0d_stop", c, frames[c]), rxs[c], 1);
              chk($sformatf("ch%0d_frame%0d_bit_width", c, frames[c]), stable[c], 1);
              chk($sformatf("ch%0d_frame%0d_frame_done_pos", c, frames[c]), fdok[c], 1);
              mst[c] = 1'b0;
              gap[c] = 0;
              frames[c]++;
            end else begin
              cyc[c]++;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int p;
    rst_v = 3'b111; en = '0; ferr = '0; clr = '0;
    tick(2);
    for (int c = 0; c < 3; c++)
      chk($sformatf("ch%0d_reset_outputs", c), {pop[c], tx[c], busy[c], fd[c], errs[c]}, 5'b01000);
    rst_v = '0;
    en    = 3'b111;

    // empty FIFO: no pops, line idle
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("t1_idle_pop_tx_busy", {pop[0], tx[0], busy[0]}, 3'b010);
    end

    // single word 0x0001: latency to pop and start bit
    push(0, 16'h0001, 1'b1);
    tick(1); chk("t2_pop_cycle",  {pop[0], tx[0], busy[0]}, 3'b111);
    tick(1); chk("t2_load_cycle", {pop[0], tx[0], busy[0]}, 3'b011);
    tick(1); chk("t2_start_bit",  {pop[0], tx[0]}, 2'b00);
    wait_frames(0, 1, 100);
    chk("t2_pop_count", pops[0], 1);

    // back-to-back words on all three instances
    push(0, 16'hA5A5, 1'b0); push(0, 16'hFFFF, 1'b0);
    push(1, 16'hA5A5, 1'b1); push(1, 16'hFFFF, 1'b1);
    push(2, 16'h1234, 1'b0); push(2, 16'h8001, 1'b0);
    wait_frames(0, 3, 400);
    wait_frames(1, 2, 50);
    wait_frames(2, 2, 50);
    chk("t3_gap_even", last_gap[0], 2);
    chk("t3_gap_odd",  last_gap[1], 2);
    chk("t7_gap_nopar", last_gap[2], 2);

    // enable dropped during bit 5 with words still queued
    p = pops[0];
    push(0, 16'h1111, 1'b0); push(0, 16'h0003, 1'b0); push(0, 16'h0007, 1'b1);
    tick(3);
    tick(20);
    en[0] = 1'b0;
    wait_frames(0, 4, 200);
    tick(10);
    chk("t4_one_pop_only", pops[0], p + 1);
    chk("t4_idle_after",   {busy[0], tx[0]}, 2'b01);
    chk("t4_words_left",   wp[0] - rp[0], 2);
    en[0] = 1'b1;
    tick(1);
    chk("t4_repop", pop[0], 1);
    wait_frames(0, 6, 400);
    chk("t4_pop_total", pops[0], p + 3);
    chk("t4_gap", last_gap[0], 2);

    // reset in data bit 8
    p = pops[0];
    push(0, 16'h00FF, 1'b0); push(0, 16'h0F0F, 1'b0);
    tick(3);
    chk("t5_start", tx[0], 0);
    tick(36);
    chk("t5_busy_in_data", busy[0], 1);
    rst_v[0] = 1'b1;
    tick(1);
    chk("t5_after_rst", {pop[0], tx[0], busy[0]}, 3'b010);
    rst_v[0] = 1'b0;
    wait_frames(0, 7, 300);
    chk("t5_pop_total", pops[0], p + 2);
    chk("t5_fifo_drained", wp[0] - rp[0], 0);

    // error latch while a frame is in flight
    push(0, 16'hC3C3, 1'b0);
    tick(10);
    ferr[0] = 1'b1; tick(1); ferr[0] = 1'b0;
    chk("t6_err_set", errs[0], 1);
    tick(1);
    chk("t6_err_hold", errs[0], 1);
    ferr[0] = 1'b1; clr[0] = 1'b1; tick(1); ferr[0] = 1'b0; clr[0] = 1'b0;
    chk("t6_set_beats_clear", errs[0], 1);
    tick(2);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("t6_err_cleared", errs[0], 0);
    chk("t6_not_stalled", busy[0], 1);
    wait_frames(0, 8, 200);

    tick(5);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ch%0d_underflow", c), underflow[c], 0);
      chk($sformatf("ch%0d_stray_frame_done", c), fd_stray[c], 0);
      chk($sformatf("ch%0d_frames_outstanding", c), ewp[c] - erp[c], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
